// File: rtl/tl_sched_if.sv
// tl_sched_if
//   Bundles the intersection sensor inputs and lamp-driver outputs of the
//   tl_sched phase scheduler so they travel as one port.
//   master modport : drives Ta/Tb/ped_req/emerg, observes La/Lb/walk/state
//   slave modport  : the scheduler side (consumes sensors, drives lamps)
//   Signals:
//     Ta, Tb   street A / street B traffic present
//     ped_req  pedestrian button, any-length pulse
//     emerg    emergency override, level
//     La, Lb   lamp codes: 00 green, 01 yellow, 10 red
//     walk     pedestrian walk lamp
//     state    current scheduler state code (debug)
interface tl_sched_if;
  logic       Ta;
  logic       Tb;
  logic       ped_req;
  logic       emerg;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic [2:0] state;

  modport master (
    output Ta, Tb, ped_req, emerg,
    input  La, Lb, walk, state
  );

  modport slave (
    input  Ta, Tb, ped_req, emerg,
    output La, Lb, walk, state
  );
endinterface

// File: rtl/tl_sched.sv
// tl_sched
//   Timed phase scheduler for a two-street intersection. Sequences street A
//   and street B through green, yellow and all-red phases, inserts a
//   pedestrian walk phase on request and yields to an emergency override.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset (returns to A green, cnt 0)
//     sched  tl_sched_if.slave: Ta, Tb, ped_req, emerg in;
//            La, Lb, walk, state out (pure decode of the state register)
module tl_sched #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  tl_sched_if.slave  sched
);

  typedef enum logic [2:0] {
    S_AG  = 3'd0,
    S_AY  = 3'd1,
    S_AR1 = 3'd2,
    S_BG  = 3'd3,
    S_BY  = 3'd4,
    S_AR2 = 3'd5,
    S_PW  = 3'd6,
    S_EMG = 3'd7
  } state_t;

  // Last-cycle counter values for each timed phase.
  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ARED_M1 = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pedPend;
  logic             r_fromAr2;
  logic             w_dA;
  logic             w_dB;
  logic             w_enterPw;
  logic             w_greenHold;

  // A pending pedestrian counts as demand on both streets.
  assign w_dA        = sched.Ta | r_pedPend;
  assign w_dB        = sched.Tb | r_pedPend;
  assign w_enterPw   = (w_next == S_PW) && (r_state != S_PW);
  assign w_greenHold = ((r_state == S_AG) || (r_state == S_BG)) && (r_cnt == GMAX_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_AG;
    end else begin
      r_state <= w_next;
    end
  end

  // Green leaves early only once the minimum has elapsed and the own street
  // has gone quiet; otherwise it leaves at the maximum if the other side waits.
  // Because cnt saturates at GREEN_MAX-1, demand arriving late still ends green
  // on the next edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_AG: begin
        if (sched.emerg || ((r_cnt >= GMIN_M1) && !sched.Ta && w_dB) ||
            ((r_cnt == GMAX_M1) && w_dB))
          w_next = S_AY;
      end
      S_BG: begin
        if (sched.emerg || ((r_cnt >= GMIN_M1) && !sched.Tb && w_dA) ||
            ((r_cnt == GMAX_M1) && w_dA))
          w_next = S_BY;
      end
      S_AY: begin
        if (r_cnt == YEL_M1) w_next = sched.emerg ? S_EMG : S_AR1;
      end
      S_BY: begin
        if (r_cnt == YEL_M1) w_next = sched.emerg ? S_EMG : S_AR2;
      end
      S_AR1: begin
        if (sched.emerg)             w_next = S_EMG;
        else if (r_cnt == ARED_M1)   w_next = r_pedPend ? S_PW : S_BG;
      end
      S_AR2: begin
        if (sched.emerg)             w_next = S_EMG;
        else if (r_cnt == ARED_M1)   w_next = r_pedPend ? S_PW : S_AG;
      end
      S_PW: begin
        if (sched.emerg)             w_next = S_EMG;
        else if (r_cnt == WALK_M1)   w_next = r_fromAr2 ? S_AG : S_BG;
      end
      S_EMG: begin
        if (!sched.emerg)            w_next = S_AR2;
      end
      default: w_next = S_AG;
    endcase
  end

  // Dwell counter: cleared on every state change, saturating during green.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (!w_greenHold) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Entering walk clears the latch even if the button is pressed that cycle,
  // and records which all-red we came from so walk resumes the right street.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pedPend <= 1'b0;
      r_fromAr2 <= 1'b0;
    end else begin
      if (w_enterPw) begin
        r_pedPend <= 1'b0;
        r_fromAr2 <= (r_state == S_AR2);
      end else if (sched.ped_req) begin
        r_pedPend <= 1'b1;
      end
    end
  end

  always_comb begin
    sched.La    = 2'b10;
    sched.Lb    = 2'b10;
    sched.walk  = 1'b0;
    sched.state = r_state;
    case (r_state)
      S_AG: sched.La = 2'b00;
      S_AY: sched.La = 2'b01;
      S_BG: sched.Lb = 2'b00;
      S_BY: sched.Lb = 2'b01;
      S_PW: sched.walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/tl_sched.md
# tl_sched

Timed phase scheduler for a two-street intersection with pedestrian and emergency service. It sequences street A and street B through green, yellow and all-red phases. Phase lengths are set by parameters. Transitions are driven by the traffic sensors Ta/Tb, a latched pedestrian request, and an emergency override. It drives the 2-bit lamp codes consumed by the intersection lamp drivers.

## Interface
Parameters:
- GREEN_MIN, 8: minimum green cycles before a sensor-driven change.
- GREEN_MAX, 20: maximum green cycles while the other side has demand.
- YELLOW_T, 3: yellow cycles.
- ALLRED_T, 1: all-red cycles.
- WALK_T, 4: pedestrian walk cycles.
- CNT_W, 5: phase counter width. Legal settings satisfy 1 ≤ YELLOW_T, ALLRED_T, WALK_T; 1 ≤ GREEN_MIN ≤ GREEN_MAX ≤ 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Ta  in  1  street A traffic present.
- Tb  in  1  street B traffic present.
- ped_req  in  1  pedestrian button, any-length pulse.
- emerg  in  1  emergency override, level.
- La  out  2  street A lamp: 00 green, 01 yellow, 10 red.
- Lb  out  2  street B lamp, same encoding.
- walk  out  1  pedestrian walk lamp.
- state  out  3  current state code, for debug.

## Operation
- States and codes: AG=0, AY=1, AR1=2, BG=3, BY=4, AR2=5, PW=6, EMG=7.
- Lamp outputs per state:
  - AG: La=00, Lb=10.
  - AY: La=01, Lb=10.
  - BG: La=10, Lb=00.
  - BY: La=10, Lb=01.
  - AR1, AR2, PW, EMG: La=Lb=10.
- walk=1 only in PW.
- Outputs are a pure decode of the state register, with no extra register stage.
- cnt (CNT_W bits) is 0 on every state entry and increments once per cycle while in the state. In AG/BG it saturates at GREEN_MAX-1.
- ped_pend is set when ped_req=1 and cleared on the edge that enters PW. If set and clear coincide, clear wins.
- Street B demand: dB = Tb | ped_pend. Street A demand: dA = Ta | ped_pend.
- Transition rules (emerg=0):
  - AG→AY when emerg, or (cnt ≥ GREEN_MIN-1 & !Ta & dB), or (cnt == GREEN_MAX-1 & dB).
  - BG→BY uses the same rule with Tb and dA.
  - No demand on the other side: green holds indefinitely.
  - AY→AR1 and BY→AR2 when cnt == YELLOW_T-1.
  - AR1→PW if ped_pend, else →BG, when cnt == ALLRED_T-1.
  - AR2→PW if ped_pend, else →AG, under the same condition.
  - PW→BG if entered from AR1; PW→AG if entered from AR2. The exit happens when cnt == WALK_T-1. A 1-bit register records the origin.
- Emergency handling:
  - emerg=1 in AG/BG forces yellow on the next edge, regardless of GREEN_MIN.
  - In yellow, the full YELLOW_T completes. If emerg is still 1 at the exit, go to EMG instead of all-red.
  - emerg=1 in AR1, AR2 or PW goes to EMG on the next edge. walk drops immediately.
  - EMG holds while emerg=1. On emerg=0, go to AR2, then resume at AG; a pending pedestrian is served via PW first.

## Timing
- Reset (asynchronous, active-high) values: state=AG, cnt=0, ped_pend=0, origin bit=0. Outputs take La=00, Lb=10, walk=0, state=0 immediately, without waiting for a clock.
- Reset asserted mid-operation aborts any phase, including yellow and walk. No restore of prior state.
- Inputs are sampled on the rising clock edge. Lamp changes appear on the same edge as the state change, i.e. one cycle after the deciding input sample.
- Phase dwell, in clock cycles:
  - yellow: exactly YELLOW_T.
  - all-red: exactly ALLRED_T.
  - walk: exactly WALK_T, unless emergency.
  - green: in [GREEN_MIN, GREEN_MAX] when demand exists on the other side, except under emergency.
- Ta/Tb changes inside the window where the green decision is made take effect on the next edge. No glitch filtering is done here.

## Test plan
- Reset, then Ta=1, Tb=0, ped_req=0 for 40 cycles → state stays AG, La=00, Lb=10, cnt holds at 19.
- Release reset with Ta=0, Tb=1 → AG for 8 cycles, AY for 3, AR1 for 1, BG entered on the 12th edge (La=10, Lb=00).
- Ta=Tb=1 held → AG 20, AY 3, AR1 1, BG 20, BY 3, AR2 1, AG; the cycle repeats with period 48.
- Ta=1, Tb=0, one-cycle ped_req pulse at AG cnt=3 → AY at cnt=19, then AR1, then PW with walk=1 for 4 cycles and ped_pend=0, then BG.
- emerg=1 at AG cnt=2, held 10 cycles → AY for 3 cycles, then EMG with La=Lb=10. After emerg falls, AR2 for 1 cycle, then AG.
- Assert reset asynchronously mid-BY → La=00, Lb=10, state=0 before the next clock edge. Normal sequencing restarts from AG cnt=0.
